// File: rtl/mpc_mac_acc_34s_if.sv
// ---------------------------------------------------------------------------
// mpc_mac_acc_34s_if
// Handshake bundle between the multiplier pipeline and the row accumulator.
//   ce        : clock enable shared with the multiplier pipeline
//   din       : signed product from the multiplier
//   in_valid  : din/in_last valid
//   in_last   : din is the last term of the current row
//   in_ready  : accumulator can accept din this cycle
//   dout      : signed rounded/saturated row result
//   out_valid : dout valid
//   out_ready : consumer takes dout
//   out_sat   : row saw accumulator or output saturation
//   term_cnt  : number of terms in the dout row (saturating)
// master = producer/consumer side, slave = accumulator side.
// ---------------------------------------------------------------------------
interface mpc_mac_acc_34s_if #(
  parameter int DIN_WIDTH  = 34,
  parameter int DOUT_WIDTH = 21,
  parameter int CNT_WIDTH  = 8
);
  logic                         ce;
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_sat;
  logic [CNT_WIDTH-1:0]         term_cnt;

  modport master (
    output ce, din, in_valid, in_last, out_ready,
    input  in_ready, dout, out_valid, out_sat, term_cnt
  );

  modport slave (
    input  ce, din, in_valid, in_last, out_ready,
    output in_ready, dout, out_valid, out_sat, term_cnt
  );
endinterface

// File: rtl/mpc_mac_acc_34s.sv
// ---------------------------------------------------------------------------
// mpc_mac_acc_34s
// Accumulates a stream of signed products over one matrix-row dot product
// (delimited by in_last), then rounds half up, rescales by FRAC_SHIFT and
// saturates to a signed DOUT_WIDTH result held in a one-entry output register
// with valid/ready backpressure.
// Ports:
//   clk    : clock, all state on rising edge
//   rst    : asynchronous active-high reset
//   mac_if : slave side of mpc_mac_acc_34s_if (ce, input stream, result)
// ---------------------------------------------------------------------------
module mpc_mac_acc_34s #(
  parameter int DIN_WIDTH  = 34,
  parameter int ACC_WIDTH  = 42,
  parameter int DOUT_WIDTH = 21,
  parameter int FRAC_SHIFT = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  mpc_mac_acc_34s_if.slave    mac_if
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  // Output clip bounds expressed in the one-bit-wider rounding domain.
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH:0] RND_HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT-1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Saturating increment: the term counter sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         first_q, first_d;
  logic [CNT_WIDTH-1:0]         run_cnt_q, run_cnt_d;
  logic                         row_sat_q, row_sat_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         out_sat_q, out_sat_d;
  logic [CNT_WIDTH-1:0]         term_cnt_q, term_cnt_d;

  logic                         in_ready_s;
  logic                         in_xfer_s;
  logic                         out_xfer_s;
  logic                         row_end_s;
  logic signed [ACC_WIDTH-1:0]  base_s;
  logic signed [ACC_WIDTH:0]    sum_wide_s;
  logic signed [ACC_WIDTH-1:0]  sum_sat_s;
  logic                         acc_ovf_s;
  logic signed [ACC_WIDTH:0]    rnd_s;
  logic signed [ACC_WIDTH:0]    shf_s;
  logic signed [DOUT_WIDTH-1:0] res_s;
  logic                         out_clip_s;
  logic                         row_sat_now_s;
  logic [CNT_WIDTH-1:0]         run_now_s;

  // Handshake qualifiers; ce=0 blocks every transfer in both directions.
  always_comb begin
    in_ready_s = mac_if.ce & ((state_q == ST_ACC) | mac_if.out_ready);
    in_xfer_s  = mac_if.in_valid & in_ready_s;
    out_xfer_s = (state_q == ST_OUT) & mac_if.out_ready & mac_if.ce;
    row_end_s  = in_xfer_s & mac_if.in_last;
  end

  // Accumulate, round, rescale and clip the candidate row result.
  always_comb begin
    if (first_q) begin
      base_s = {ACC_WIDTH{1'b0}};
    end else begin
      base_s = acc_q;
    end
    sum_wide_s = {base_s[ACC_WIDTH-1], base_s}
               + {{(ACC_WIDTH+1-DIN_WIDTH){mac_if.din[DIN_WIDTH-1]}}, mac_if.din};
    // Overflow when the guard bit disagrees with the accumulator sign bit.
    if (sum_wide_s[ACC_WIDTH] != sum_wide_s[ACC_WIDTH-1]) begin
      acc_ovf_s = 1'b1;
      if (sum_wide_s[ACC_WIDTH]) begin
        sum_sat_s = ACC_MIN;
      end else begin
        sum_sat_s = ACC_MAX;
      end
    end else begin
      acc_ovf_s = 1'b0;
      sum_sat_s = sum_wide_s[ACC_WIDTH-1:0];
    end
    // One extra bit so adding the half-LSB never wraps at ACC_MAX.
    rnd_s = {sum_sat_s[ACC_WIDTH-1], sum_sat_s} + RND_HALF;
    shf_s = rnd_s >>> FRAC_SHIFT;
    if (shf_s > OUT_MAX) begin
      out_clip_s = 1'b1;
      res_s      = OUT_MAX[DOUT_WIDTH-1:0];
    end else if (shf_s < OUT_MIN) begin
      out_clip_s = 1'b1;
      res_s      = OUT_MIN[DOUT_WIDTH-1:0];
    end else begin
      out_clip_s = 1'b0;
      res_s      = shf_s[DOUT_WIDTH-1:0];
    end
    if (first_q) begin
      row_sat_now_s = acc_ovf_s;
      run_now_s     = CNT_ONE;
    end else begin
      row_sat_now_s = row_sat_q | acc_ovf_s;
      run_now_s     = sat_inc(run_cnt_q);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a row end always lands in OUT, even while popping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC: begin
        if (row_end_s) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (row_end_s) begin
          state_d = ST_OUT;
        end else if (out_xfer_s) begin
          state_d = ST_ACC;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // FSM outputs.
  always_comb begin
    mac_if.in_ready  = in_ready_s;
    mac_if.out_valid = (state_q == ST_OUT);
    mac_if.dout      = dout_q;
    mac_if.out_sat   = out_sat_q;
    mac_if.term_cnt  = term_cnt_q;
  end

  // Datapath next state; nothing moves without an input transfer.
  always_comb begin
    acc_d      = acc_q;
    first_d    = first_q;
    run_cnt_d  = run_cnt_q;
    row_sat_d  = row_sat_q;
    dout_d     = dout_q;
    out_sat_d  = out_sat_q;
    term_cnt_d = term_cnt_q;
    if (in_xfer_s) begin
      acc_d     = sum_sat_s;
      first_d   = mac_if.in_last;
      run_cnt_d = run_now_s;
      if (mac_if.in_last) begin
        row_sat_d  = 1'b0;
        dout_d     = res_s;
        out_sat_d  = row_sat_now_s | out_clip_s;
        term_cnt_d = run_now_s;
      end else begin
        row_sat_d  = row_sat_now_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= {ACC_WIDTH{1'b0}};
      first_q    <= 1'b1;
      run_cnt_q  <= {CNT_WIDTH{1'b0}};
      row_sat_q  <= 1'b0;
      dout_q     <= {DOUT_WIDTH{1'b0}};
      out_sat_q  <= 1'b0;
      term_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      acc_q      <= acc_d;
      first_q    <= first_d;
      run_cnt_q  <= run_cnt_d;
      row_sat_q  <= row_sat_d;
      dout_q     <= dout_d;
      out_sat_q  <= out_sat_d;
      term_cnt_q <= term_cnt_d;
    end
  end

endmodule

// File: tb/tb_mpc_mac_acc_34s.sv
// ---------------------------------------------------------------------------
// tb_mpc_mac_acc_34s
// Directed bench for the row accumulator. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or 1 ns after an input change for
// the combinational in_ready), away from the rising active edge.
// ---------------------------------------------------------------------------
module tb_mpc_mac_acc_34s;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mpc_mac_acc_34s_if #(.DIN_WIDTH(34), .DOUT_WIDTH(21), .CNT_WIDTH(8)) bus ();

  mpc_mac_acc_34s #(
    .DIN_WIDTH (34),
    .ACC_WIDTH (42),
    .DOUT_WIDTH(21),
    .FRAC_SHIFT(12),
    .CNT_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .mac_if(bus)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one term for one cycle; it must be accepted.
  task automatic push(input logic signed [33:0] d, input logic last);
    bus.din      = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    #1;
    chk("push_in_ready", longint'(bus.in_ready), 64'sd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Take the held result; out_valid must drop afterwards.
  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("pop_out_valid", longint'(bus.out_valid), 64'sd0);
  endtask

  task automatic chk_res(input string tag, input longint d, input longint tc, input longint st);
    chk({tag, "_valid"}, longint'(bus.out_valid), 64'sd1);
    chk({tag, "_dout"}, longint'(bus.dout), d);
    chk({tag, "_term_cnt"}, longint'(bus.term_cnt), tc);
    chk({tag, "_out_sat"}, longint'(bus.out_sat), st);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.ce        = 1'b1;
    bus.din       = 34'sd0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 64'sd0);
    chk("rst_dout", longint'(bus.dout), 64'sd0);
    chk("rst_out_sat", longint'(bus.out_sat), 64'sd0);
    chk("rst_term_cnt", longint'(bus.term_cnt), 64'sd0);
    chk("rst_in_ready", longint'(bus.in_ready), 64'sd1);
    @(negedge clk);
    rst = 1'b0;

    // Three-term row: (10240 + 2048) >>> 12 = 3.
    push(34'sd4096, 1'b0);
    push(34'sd8192, 1'b0);
    push(-34'sd2048, 1'b1);
    chk_res("row3", 64'sd3, 64'sd3, 64'sd0);
    chk("row3_held_in_ready", longint'(bus.in_ready), 64'sd0);
    pop();

    // Single-term rows, round half up.
    push(-34'sd6144, 1'b1);
    chk_res("single_neg", -64'sd1, 64'sd1, 64'sd0);
    pop();
    push(-34'sd2048, 1'b1);
    chk_res("single_half", 64'sd0, 64'sd1, 64'sd0);
    pop();

    // Output saturation, both directions.
    push(34'sh1_FFFF_FFFF, 1'b0);
    push(34'sh1_FFFF_FFFF, 1'b1);
    chk_res("sat_pos", 64'sd1048575, 64'sd2, 64'sd1);
    pop();
    push(34'sh2_0000_0000, 1'b0);
    push(34'sh2_0000_0000, 1'b1);
    chk_res("sat_neg", -64'sd1048576, 64'sd2, 64'sd1);
    pop();
    // The saturation flag must not leak into the next row.
    push(34'sd4096, 1'b1);
    chk_res("sat_clear", 64'sd1, 64'sd1, 64'sd0);
    pop();

    // Term counter sticks at 255 on a 300-term row.
    for (int i = 0; i < 299; i++) begin
      push(34'sd0, 1'b0);
    end
    push(34'sd0, 1'b1);
    chk_res("cnt_sat", 64'sd0, 64'sd255, 64'sd0);
    pop();

    // Backpressure: result held 5 cycles while the next row's first term waits.
    push(34'sd4096, 1'b1);
    bus.din      = 34'sd8192;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", longint'(bus.in_ready), 64'sd0);
      chk("bp_out_valid", longint'(bus.out_valid), 64'sd1);
      chk("bp_dout", longint'(bus.dout), 64'sd1);
      chk("bp_term_cnt", longint'(bus.term_cnt), 64'sd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", longint'(bus.in_ready), 64'sd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp_popped", longint'(bus.out_valid), 64'sd0);
    push(34'sd4096, 1'b1);
    chk_res("bp_next_row", 64'sd3, 64'sd2, 64'sd0);
    // Pop and accept a whole single-term row on the same edge.
    bus.out_ready = 1'b1;
    push(-34'sd6144, 1'b1);
    bus.out_ready = 1'b0;
    chk_res("thru_row", -64'sd1, 64'sd1, 64'sd0);
    pop();

    // ce=0 mid-row freezes everything.
    push(34'sd4096, 1'b0);
    bus.ce       = 1'b0;
    bus.din      = 34'sd8192;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ce_in_ready", longint'(bus.in_ready), 64'sd0);
      chk("ce_out_valid", longint'(bus.out_valid), 64'sd0);
      @(negedge clk);
    end
    bus.ce       = 1'b1;
    bus.in_valid = 1'b0;
    push(34'sd8192, 1'b0);
    push(-34'sd2048, 1'b1);
    chk_res("ce_row", 64'sd3, 64'sd3, 64'sd0);
    // ce=0 also blocks the pop.
    bus.ce        = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ce_hold_valid", longint'(bus.out_valid), 64'sd1);
    chk("ce_hold_dout", longint'(bus.dout), 64'sd3);
    bus.out_ready = 1'b0;
    bus.ce        = 1'b1;

    // Reset with a held result drops it immediately.
    rst = 1'b1;
    #1;
    chk("rst_held_valid", longint'(bus.out_valid), 64'sd0);
    chk("rst_held_dout", longint'(bus.dout), 64'sd0);
    chk("rst_held_term_cnt", longint'(bus.term_cnt), 64'sd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-row discards the partial sum.
    push(34'sd4096, 1'b0);
    push(34'sd4096, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", longint'(bus.out_valid), 64'sd0);
    @(negedge clk);
    rst = 1'b0;
    push(34'sd4096, 1'b1);
    chk_res("after_rst", 64'sd1, 64'sd1, 64'sd0);
    pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
